// File: rtl/io_bridge_pkg.sv
// Shared types and constants for the memory-mapped byte I/O bridge.
package io_bridge_pkg;

    typedef logic [7:0] word;

    localparam word IO_DATA_OFS   = 8'd0;
    localparam word IO_STATUS_OFS = 8'd1;

    // Bit positions inside the STATUS register.
    typedef enum logic [2:0] {
        ST_RX_EMPTY = 3'd0,
        ST_RX_FULL  = 3'd1,
        ST_TX_EMPTY = 3'd2,
        ST_TX_FULL  = 3'd3,
        ST_RX_UNDER = 3'd4,
        ST_TX_OVER  = 3'd5
    } status_bit_e;

endpackage

// File: rtl/byte_fifo.sv
// First-word fall-through byte FIFO; push is accepted while full if a pop
// happens on the same edge.
module byte_fifo
    import io_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  word  push_data,
    input  logic pop,
    output word  head,
    output logic empty,
    output logic full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    word           mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped byte I/O responder: DATA/STATUS registers on the core data bus
// bridging to external RX and TX valid/ready byte streams.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter word BASE_ADDR = 8'hF0,
    parameter int  DEPTH     = 4
) (
    input  logic clk,
    input  logic rst,
    input  word  bus_addr,
    input  word  bus_wr_data,
    input  logic bus_wr_en,
    input  logic bus_rd_en,
    output word  bus_rd_data,
    output logic bus_hit,
    input  word  in_data,
    input  logic in_valid,
    output logic in_ready,
    output word  out_data,
    output logic out_valid,
    input  logic out_ready
);

    localparam word DATA_ADDR   = BASE_ADDR + IO_DATA_OFS;
    localparam word STATUS_ADDR = BASE_ADDR + IO_STATUS_OFS;

    logic hit_data, hit_status;
    logic rx_empty, rx_full, tx_empty, tx_full;
    word  rx_head, tx_head;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic rx_under, tx_over, set_under, set_over, clr_sticky;
    word  status;

    assign hit_data   = (bus_addr == DATA_ADDR);
    assign hit_status = (bus_addr == STATUS_ADDR);
    assign bus_hit    = hit_data || hit_status;

    // Stream handshake: a byte moves on a rising edge exactly when valid and
    // ready are both high; ready/valid driven here come only from FIFO state.
    assign in_ready  = !rx_full;
    assign out_valid = !tx_empty;
    assign out_data  = tx_head;
    assign rx_push   = in_valid && in_ready;
    assign tx_pop    = out_valid && out_ready;

    assign rx_pop     = hit_data && bus_rd_en && !rx_empty;
    assign set_under  = hit_data && bus_rd_en && rx_empty;
    assign tx_push    = hit_data && bus_wr_en;
    assign set_over   = tx_push && tx_full && !tx_pop;
    assign clr_sticky = hit_status && bus_wr_en;

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .push_data(in_data),
        .pop(rx_pop), .head(rx_head), .empty(rx_empty), .full(rx_full)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .push_data(bus_wr_data),
        .pop(tx_pop), .head(tx_head), .empty(tx_empty), .full(tx_full)
    );

    // A new violation on the same edge as a STATUS write keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_under <= 1'b0;
            tx_over  <= 1'b0;
        end else begin
            rx_under <= set_under || (rx_under && !clr_sticky);
            tx_over  <= set_over  || (tx_over  && !clr_sticky);
        end
    end

    always_comb begin
        status              = '0;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_UNDER] = rx_under;
        status[ST_TX_OVER]  = tx_over;
    end

    always_comb begin
        bus_rd_data = '0;
        if (hit_data)
            bus_rd_data = rx_empty ? '0 : rx_head;
        else if (hit_status)
            bus_rd_data = status;
    end

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_io_bridge;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] bus_addr;
    logic [7:0] bus_wr_data;
    logic       bus_wr_en;
    logic       bus_rd_en;
    logic [7:0] bus_rd_data;
    logic       bus_hit;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       m_under = 1'b0;
    logic       m_over  = 1'b0;
    logic [7:0] got_q[$];

    io_bridge #(.BASE_ADDR(8'hF0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en),
        .bus_rd_data(bus_rd_data), .bus_hit(bus_hit),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_rd(input logic [7:0] addr);
        logic [7:0] r;
        r = 8'h00;
        if (addr == 8'hF0)
            r = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        else if (addr == 8'hF1)
            r = {2'b00, m_over, m_under,
                 logic'(exp_q.size() == DEPTH), logic'(exp_q.size() == 0),
                 logic'(rx_q.size() == DEPTH), logic'(rx_q.size() == 0)};
        return r;
    endfunction

    always @(negedge rst) begin
        exp_q.delete();
        rx_q.delete();
        m_under = 1'b0;
        m_over  = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            int  tsz;
            bit  tpop, rpush, hd, hs, set_u, set_o, clr;
            tsz   = exp_q.size();
            tpop  = (tsz > 0) && out_ready;
            rpush = in_valid && (rx_q.size() < DEPTH);
            hd    = (bus_addr == 8'hF0);
            hs    = (bus_addr == 8'hF1);
            set_u = 1'b0;
            set_o = 1'b0;
            clr   = hs && bus_wr_en;
            if (tpop) got_q.push_back(out_data);
            if (hd && bus_rd_en) begin
                if (rx_q.size() > 0) void'(rx_q.pop_front());
                else set_u = 1'b1;
            end
            if (tpop) void'(exp_q.pop_front());
            if (hd && bus_wr_en) begin
                if (tsz < DEPTH || tpop) exp_q.push_back(bus_wr_data);
                else set_o = 1'b1;
            end
            if (rpush) rx_q.push_back(in_data);
            m_under = set_u || (m_under && !clr);
            m_over  = set_o || (m_over && !clr);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("cyc_bus_hit", {7'b0, bus_hit},
              {7'b0, logic'(bus_addr == 8'hF0 || bus_addr == 8'hF1)});
        check("cyc_rd_data", bus_rd_data, model_rd(bus_addr));
        check("cyc_in_ready", {7'b0, in_ready}, {7'b0, logic'(rx_q.size() < DEPTH)});
        check("cyc_out_valid", {7'b0, out_valid}, {7'b0, logic'(exp_q.size() > 0)});
        if (exp_q.size() > 0)
            check("cyc_out_data", out_data, exp_q[0]);
    end

    // ---------------- driver tasks ----------------
    task automatic bus_op(input logic [7:0] addr, input logic [7:0] wd,
                          input logic we, input logic re);
        bus_addr    = addr;
        bus_wr_data = wd;
        bus_wr_en   = we;
        bus_rd_en   = re;
        @(posedge clk);
        #1;
        bus_wr_en = 1'b0;
        bus_rd_en = 1'b0;
    endtask

    task automatic peek(input string name, input logic [7:0] addr, input logic [7:0] exp);
        bus_addr  = addr;
        bus_wr_en = 1'b0;
        bus_rd_en = 1'b0;
        #1;
        check(name, bus_rd_data, exp);
    endtask

    task automatic check_got(input int idx, input logic [7:0] exp);
        logic [7:0] v;
        v = (idx < got_q.size()) ? got_q[idx] : 8'hxx;
        check("sink_byte", v, exp);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [7:0] tx_bytes [4];
        tx_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        rst = 1'b0;
        bus_addr = 8'h00; bus_wr_data = 8'h00; bus_wr_en = 1'b0; bus_rd_en = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state and underflow
        peek("status_after_reset", 8'hF1, 8'h05);
        check("in_ready_reset", {7'b0, in_ready}, 8'h01);
        check("out_valid_reset", {7'b0, out_valid}, 8'h00);
        peek("data_empty", 8'hF0, 8'h00);
        bus_op(8'hF0, 8'h00, 1'b0, 1'b1);
        peek("status_rx_under", 8'hF1, 8'h15);
        bus_op(8'hF1, 8'hFF, 1'b1, 1'b0);
        peek("status_cleared", 8'hF1, 8'h05);

        // Fill TX, overflow, drain
        for (int i = 0; i < 4; i++) bus_op(8'hF0, tx_bytes[i], 1'b1, 1'b0);
        peek("status_tx_full", 8'hF1, 8'h09);
        bus_op(8'hF0, 8'hE5, 1'b1, 1'b0);
        peek("status_tx_over", 8'hF1, 8'h29);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 4; i++) check_got(i, tx_bytes[i]);
        peek("status_drained", 8'hF1, 8'h25);
        bus_op(8'hF1, 8'h00, 1'b1, 1'b0);
        peek("status_over_clr", 8'hF1, 8'h05);

        // Store while full in the same cycle as an external pop
        bus_op(8'hF0, 8'h11, 1'b1, 1'b0);
        bus_op(8'hF0, 8'h22, 1'b1, 1'b0);
        bus_op(8'hF0, 8'h33, 1'b1, 1'b0);
        bus_op(8'hF0, 8'h44, 1'b1, 1'b0);
        out_ready = 1'b1;
        bus_op(8'hF0, 8'h77, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        check_got(4, 8'h11);
        check_got(8, 8'h77);
        check("sink_count", 8'(got_q.size()), 8'd9);
        peek("status_no_over", 8'hF1, 8'h05);

        // RX fill with back-pressure
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h10 + 8'(i);
            @(posedge clk);
            #1;
        end
        in_data = 8'h14;
        check("in_ready_full", {7'b0, in_ready}, 8'h00);
        peek("status_rx_full", 8'hF1, 8'h06);
        peek("data_peek_1", 8'hF0, 8'h10);
        @(posedge clk);
        #1;
        peek("data_peek_2", 8'hF0, 8'h10);
        bus_op(8'hF0, 8'h00, 1'b0, 1'b1);
        peek("data_rd_11", 8'hF0, 8'h11);
        bus_op(8'hF0, 8'h00, 1'b0, 1'b1);
        in_valid = 1'b0;
        peek("data_rd_12", 8'hF0, 8'h12);
        bus_op(8'hF0, 8'h00, 1'b0, 1'b1);
        peek("data_rd_13", 8'hF0, 8'h13);
        bus_op(8'hF0, 8'h00, 1'b0, 1'b1);
        peek("data_rd_14", 8'hF0, 8'h14);
        bus_op(8'hF0, 8'h00, 1'b0, 1'b1);
        peek("status_rx_done", 8'hF1, 8'h05);

        // Out-of-window accesses
        peek("miss_f2", 8'hF2, 8'h00);
        check("miss_f2_hit", {7'b0, bus_hit}, 8'h00);
        bus_op(8'hF2, 8'h55, 1'b1, 1'b1);
        bus_op(8'h00, 8'h66, 1'b1, 1'b1);
        peek("status_after_miss", 8'hF1, 8'h05);
        check("out_valid_after_miss", {7'b0, out_valid}, 8'h00);

        // Asynchronous reset mid-stream
        bus_op(8'hF0, 8'h5A, 1'b1, 1'b0);
        bus_op(8'hF0, 8'h6B, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hC1;
        @(posedge clk);
        #1 in_data = 8'hC2;
        @(posedge clk);
        #1 in_valid = 1'b0;
        peek("status_partial", 8'hF1, 8'h00);
        rst = 1'b0;
        #1;
        check("in_ready_async_rst", {7'b0, in_ready}, 8'h01);
        check("out_valid_async_rst", {7'b0, out_valid}, 8'h00);
        check("status_async_rst", bus_rd_data, 8'h05);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        peek("status_post_rst", 8'hF1, 8'h05);
        peek("data_post_rst", 8'hF0, 8'h00);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
